// File: rtl/bus_master_if.sv
// Peripheral bus initiator: turns one client request at a time into a cs_/as_ bus cycle.
// It waits for rdy_ (or times out) and holds the response until the client takes it.
module bus_master_if #(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wr_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rd_data,
  output logic              resp_err,
  output logic              busy,
  output logic              cs_,
  output logic              as_,
  output logic              rw,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rdy_
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  // Counter holds (BUS cycles elapsed - 1), so the last allowed cycle sees TIMEOUT-1.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state;
  logic [TO_W-1:0] count;
  logic            ack;
  logic            timeout_hit;

  // rdy_ in the first BUS cycle may be left over from a previous cycle, so it is ignored.
  assign ack         = !rdy_ && (count != '0);
  assign timeout_hit = (count == TO_LAST);
  assign req_ready   = (state == IDLE);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      count        <= '0;
      cs_          <= 1'b1;
      as_          <= 1'b1;
      rw           <= 1'b1;
      addr         <= '0;
      wr_data      <= '0;
      resp_valid   <= 1'b0;
      resp_rd_data <= '0;
      resp_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            rw      <= req_rw;
            addr    <= req_addr;
            wr_data <= req_rw ? '0 : req_wr_data;
            cs_     <= 1'b0;
            as_     <= 1'b0;
            count   <= '0;
            state   <= BUS;
          end
        end
        BUS: begin
          count <= (count == '1) ? count : count + 1'b1;
          if (ack) begin
            resp_rd_data <= rw ? rd_data : '0;
            resp_err     <= 1'b0;
            cs_          <= 1'b1;
            as_          <= 1'b1;
            state        <= RESP;
          end else if (timeout_hit) begin
            resp_rd_data <= '0;
            resp_err     <= 1'b1;
            cs_          <= 1'b1;
            as_          <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          // First RESP cycle raises resp_valid; the handshake completes only once it is visible.
          if (!resp_valid) begin
            resp_valid <= 1'b1;
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_if.sv
// Testbench for bus_master_if: directed and random transactions against a cycle-count model
// of the bus handshake (ack cycle, timeout, response hold) with TIMEOUT=8.
module tb_bus_master_if;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int TMO    = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wr_data;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rd_data;
  logic              resp_err;
  logic              busy;
  logic              cs_;
  logic              as_;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              rdy_;

  int n_cmp = 0;
  int n_err = 0;
  int hi_run = 100;
  int last_gap = 100;

  bus_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TMO), .TO_W(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wr_data(req_wr_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rd_data(resp_rd_data), .resp_err(resp_err), .busy(busy),
    .cs_(cs_), .as_(as_), .rw(rw), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .rdy_(rdy_)
  );

  always #5 clk = ~clk;

  // Length of the most recent run of strobe-high cycles before a bus cycle.
  always @(negedge clk) begin
    if (cs_) hi_run <= hi_run + 1;
    else begin
      if (hi_run != 0) last_gap <= hi_run;
      hi_run <= 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit rdy_low(input int n, input int rdy_at, input bit stale);
    return (stale && n == 1) || (rdy_at != 0 && n >= rdy_at);
  endfunction

  // One full request/response exchange, starting at a negedge with the DUT idle.
  // rdy_at: first BUS cycle (1-based) with rdy_ low, 0 = never; stale: rdy_ low in cycle 1 only.
  task automatic run_txn(input logic r, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                         input logic [DATA_W-1:0] rdd, input int rdy_at, input bit stale, input int hold);
    int exp_n;
    bit exp_err;
    logic [DATA_W-1:0] exp_rd;
    exp_n = 0;
    for (int n = 2; n <= TMO; n++)
      if (exp_n == 0 && rdy_low(n, rdy_at, stale)) exp_n = n;
    exp_err = (exp_n == 0);
    if (exp_err) exp_n = TMO;
    exp_rd = (exp_err || !r) ? '0 : rdd;

    chk("idle_req_ready", req_ready, 1);
    chk("idle_busy", busy, 0);
    req_valid = 1'b1; req_rw = r; req_addr = a; req_wr_data = wd;
    rdy_ = 1'($urandom_range(0, 1));
    resp_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    req_valid = 1'b0; req_wr_data = $urandom;
    for (int n = 1; n <= exp_n; n++) begin
      chk("bus_cs", cs_, 0);
      chk("bus_as", as_, 0);
      chk("bus_rw", rw, r);
      chk("bus_addr", addr, a);
      chk("bus_wr_data", wr_data, r ? '0 : wd);
      chk("bus_req_ready", req_ready, 0);
      chk("bus_busy", busy, 1);
      if (n == 2) chk("strobe_gap_ge2", last_gap >= 2, 1);
      rdy_ = rdy_low(n, rdy_at, stale) ? 1'b0 : 1'b1;
      rd_data = rdy_low(n, rdy_at, stale) ? rdd : $urandom;
      @(negedge clk);
    end
    chk("resp0_cs", cs_, 1);
    chk("resp0_valid", resp_valid, 0);
    rdy_ = 1'($urandom_range(0, 1));
    resp_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    rdy_ = 1'b1;
    for (int h = 0; h <= hold; h++) begin
      chk("resp_valid", resp_valid, 1);
      chk("resp_rd_data", resp_rd_data, exp_rd);
      chk("resp_err", resp_err, exp_err);
      chk("resp_req_ready", req_ready, 0);
      chk("resp_cs", cs_, 1);
      resp_ready = (h == hold);
      @(negedge clk);
    end
    resp_ready = 1'b0;
    chk("post_valid", resp_valid, 0);
    chk("post_req_ready", req_ready, 1);
    chk("post_err_hold", resp_err, exp_err);
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_wr_data = '0;
    resp_ready = 1'b0; rd_data = '0; rdy_ = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cs", cs_, 1);
    chk("rst_as", as_, 1);
    chk("rst_rw", rw, 1);
    chk("rst_addr", addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rd_data", resp_rd_data, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 1);
    reset = 1'b1;
    @(negedge clk);

    // Read with rdy_ one cycle after the strobe: strobes low exactly 2 cycles.
    run_txn(1'b1, 30'd2, 32'hdead_beef, 32'h0000_1234, 2, 1'b0, 0);
    // Write of 3 to address 0.
    run_txn(1'b0, 30'd0, 32'h3, 32'hffff_ffff, 2, 1'b0, 0);
    // Responder silent: timeout after TIMEOUT bus cycles.
    run_txn(1'b1, 30'h155, 32'h0, 32'h5555_5555, 0, 1'b0, 0);
    // Ack in the very last allowed cycle wins over timeout.
    run_txn(1'b1, 30'h77, 32'h0, 32'hcafe_0001, TMO, 1'b0, 1);
    // Ack one cycle too late for the budget.
    run_txn(1'b1, 30'h78, 32'h0, 32'hcafe_0002, TMO + 1, 1'b0, 0);
    // Client stalls 5 cycles on the response.
    run_txn(1'b1, 30'h3ff, 32'h0, 32'h0bad_f00d, 3, 1'b0, 5);
    // Back-to-back, second one with stale rdy_ only in its first BUS cycle.
    run_txn(1'b0, 30'h10, 32'h1111_2222, 32'h0, 2, 1'b0, 0);
    run_txn(1'b1, 30'h11, 32'h0, 32'h3333_4444, 5, 1'b1, 0);
    run_txn(1'b1, 30'h12, 32'h0, 32'h6666_7777, 0, 1'b1, 0);

    for (int i = 0; i < 25; i++)
      run_txn(1'($urandom_range(0, 1)), ADDR_W'($urandom), $urandom, $urandom,
              int'($urandom_range(0, TMO + 2)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)));

    // Reset in the second BUS cycle drops the transfer.
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 30'h42; rdy_ = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_cs", cs_, 0);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_cs", cs_, 1);
    chk("async_rst_as", as_, 1);
    chk("async_rst_busy", busy, 0);
    rdy_ = 1'b0; rd_data = 32'h9999_9999;
    @(negedge clk);
    reset = 1'b1; resp_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("after_rst_resp_valid", resp_valid, 0);
      chk("after_rst_busy", busy, 0);
      chk("after_rst_cs", cs_, 1);
    end
    resp_ready = 1'b0; rdy_ = 1'b1;
    run_txn(1'b1, 30'h43, 32'h0, 32'h1357_9bdf, 4, 1'b0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
